// File: rtl/ila_pkg.sv
// rtl/ila_pkg.sv - shared constants for the logic analyzer trigger/stop path
package ila_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_STOPPED   = 3'd4
    } state_e;

    localparam logic COMB_OR  = 1'b0;
    localparam logic COMB_AND = 1'b1;

    localparam int HOLDOFF_WIDTH_DEF = 16;

endpackage

// File: rtl/trigger_stop_ctrl_if.sv
// rtl/trigger_stop_ctrl_if.sv - control/status bundle between capture control and the trigger block
interface trigger_stop_ctrl_if #(
    parameter int NUM_CH        = 4,
    parameter int HOLDOFF_WIDTH = ila_pkg::HOLDOFF_WIDTH_DEF
);
    logic                     i_arm;
    logic                     i_abort;
    logic                     i_primed;
    logic                     i_force;
    logic [NUM_CH-1:0]        i_probe;
    logic [NUM_CH-1:0]        i_mask;
    logic [NUM_CH-1:0]        i_polarity;
    logic                     i_edge_mode;
    logic                     i_combine;
    logic [HOLDOFF_WIDTH-1:0] i_holdoff;
    logic [2:0]               o_state;
    logic                     o_wr_en;
    logic                     o_triggered;
    logic                     o_stopped;
    logic [NUM_CH-1:0]        o_trig_ch;

    modport master (
        output i_arm, i_abort, i_primed, i_force, i_probe, i_mask, i_polarity,
               i_edge_mode, i_combine, i_holdoff,
        input  o_state, o_wr_en, o_triggered, o_stopped, o_trig_ch
    );

    modport slave (
        input  i_arm, i_abort, i_primed, i_force, i_probe, i_mask, i_polarity,
               i_edge_mode, i_combine, i_holdoff,
        output o_state, o_wr_en, o_triggered, o_stopped, o_trig_ch
    );

endinterface

// File: rtl/trigger_match.sv
// rtl/trigger_match.sv - probe pipeline, per-channel level/edge match and OR/AND combine
module trigger_match
    import ila_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] probe_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [NUM_CH-1:0] polarity_i,
    input  logic              edge_mode_i,
    input  logic              combine_i,
    output logic              hit_o,
    output logic [NUM_CH-1:0] m_o
);

    logic [NUM_CH-1:0] p1_q;
    logic [NUM_CH-1:0] p2_q;
    logic [NUM_CH-1:0] level_m;
    logic [NUM_CH-1:0] prev_active;

    // Pipeline runs in every state and is only cleared by reset, never by abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q <= '0;
            p2_q <= '0;
        end else begin
            p1_q <= probe_i;
            p2_q <= p1_q;
        end
    end

    always_comb begin
        level_m     = ~(p1_q ^ polarity_i);
        prev_active = ~(p2_q ^ polarity_i);
        m_o         = edge_mode_i ? (level_m & ~prev_active) : level_m;
        hit_o       = 1'b0;
        if (mask_i != '0) begin
            if (combine_i == COMB_AND) begin
                hit_o = &(m_o | ~mask_i);
            end else begin
                hit_o = |(m_o & mask_i);
            end
        end
    end

endmodule

// File: rtl/trigger_stop_ctrl.sv
// rtl/trigger_stop_ctrl.sv - capture sequencer: arm, fill, wait for trigger, holdoff, stop
module trigger_stop_ctrl
    import ila_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int HOLDOFF_WIDTH = HOLDOFF_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    trigger_stop_ctrl_if.slave bus
);

    state_e                   state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
    logic                     triggered_q, triggered_d;
    logic [NUM_CH-1:0]        trig_ch_q, trig_ch_d;
    logic                     hit;
    logic [NUM_CH-1:0]        m;

    trigger_match #(.NUM_CH(NUM_CH)) u_match (
        .clk         (clk),
        .reset       (reset),
        .probe_i     (bus.i_probe),
        .mask_i      (bus.i_mask),
        .polarity_i  (bus.i_polarity),
        .edge_mode_i (bus.i_edge_mode),
        .combine_i   (bus.i_combine),
        .hit_o       (hit),
        .m_o         (m)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            triggered_q <= 1'b0;
            trig_ch_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            triggered_q <= triggered_d;
            trig_ch_q   <= trig_ch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        triggered_d = triggered_q;
        trig_ch_d   = trig_ch_q;
        if (bus.i_abort) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            triggered_d = 1'b0;
            trig_ch_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_STOPPED: begin
                    if (bus.i_arm) begin
                        state_d     = ST_FILL;
                        cnt_d       = '0;
                        triggered_d = 1'b0;
                        trig_ch_d   = '0;
                    end
                end
                ST_FILL: begin
                    if (bus.i_primed) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (hit || bus.i_force) begin
                        trig_ch_d   = m & bus.i_mask;
                        triggered_d = 1'b1;
                        if (bus.i_holdoff == '0) begin
                            state_d = ST_STOPPED;
                        end else begin
                            state_d = ST_POST;
                            cnt_d   = bus.i_holdoff;
                        end
                    end
                end
                ST_POST: begin
                    // Count is loaded nonzero on entry, so it reaches 1 before it could wrap.
                    cnt_d = cnt_q - HOLDOFF_WIDTH'(1);
                    if (cnt_q == HOLDOFF_WIDTH'(1)) begin
                        state_d = ST_STOPPED;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    triggered_d = 1'b0;
                    trig_ch_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_state     = state_q;
        bus.o_wr_en     = (state_q == ST_FILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
        bus.o_stopped   = (state_q == ST_STOPPED);
        bus.o_triggered = triggered_q;
        bus.o_trig_ch   = trig_ch_q;
    end

endmodule

// File: tb/tb_trigger_stop_ctrl.sv
// tb/tb_trigger_stop_ctrl.sv - directed and randomized check of trigger_stop_ctrl against a behavioural model
module tb_trigger_stop_ctrl;
    import ila_pkg::*;

    localparam int NCH = 4;
    localparam int HW  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trigger_stop_ctrl_if #(.NUM_CH(NCH), .HOLDOFF_WIDTH(HW)) bus ();

    trigger_stop_ctrl #(.NUM_CH(NCH), .HOLDOFF_WIDTH(HW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: phase 0..4, trigger flag, latched vector, remaining post samples, probe history
    int           mst = 0;
    bit           mtrig = 1'b0;
    bit [NCH-1:0] mtch = '0;
    int           mleft = 0;
    bit [NCH-1:0] mp1 = '0;
    bit [NCH-1:0] mp2 = '0;
    int           post_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mtrig = 1'b0;
        mtch  = '0;
        mleft = 0;
    endtask

    task automatic model_step();
        bit [NCH-1:0] mv;
        bit any_m, all_m, hit, lvl;
        if (reset) begin
            mst = 0;
            model_clear();
            mp1 = '0;
            mp2 = '0;
            return;
        end
        any_m = 1'b0;
        all_m = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            lvl   = (mp1[i] == bus.i_polarity[i]);
            mv[i] = bus.i_edge_mode ? (lvl && (mp2[i] != bus.i_polarity[i])) : lvl;
            if (bus.i_mask[i]) begin
                any_m = any_m | mv[i];
                all_m = all_m & mv[i];
            end
        end
        hit = (bus.i_mask == '0) ? 1'b0 : (bus.i_combine ? all_m : any_m);
        if (bus.i_abort) begin
            mst = 0;
            model_clear();
        end else if (mst == 0 || mst == 4) begin
            if (bus.i_arm) begin
                mst = 1;
                model_clear();
            end
        end else if (mst == 1) begin
            if (bus.i_primed) mst = 2;
        end else if (mst == 2) begin
            if (hit || bus.i_force) begin
                mtch  = mv & bus.i_mask;
                mtrig = 1'b1;
                mleft = int'(bus.i_holdoff);
                mst   = (mleft == 0) ? 4 : 3;
            end
        end else if (mst == 3) begin
            mleft = mleft - 1;
            if (mleft == 0) mst = 4;
        end
        mp2 = mp1;
        mp1 = bus.i_probe;
    endtask

    task automatic compare_all();
        chk("state",     32'(bus.o_state),     32'(mst));
        chk("wr_en",     32'(bus.o_wr_en),     32'(mst == 1 || mst == 2 || mst == 3));
        chk("stopped",   32'(bus.o_stopped),   32'(mst == 4));
        chk("triggered", 32'(bus.o_triggered), 32'(mtrig));
        chk("trig_ch",   32'(bus.o_trig_ch),   32'(mtch));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (bus.o_state == 3'd3) post_cycles++;
    endtask

    task automatic arm_and_prime();
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        bus.i_primed = 1'b1;
        tick();
        bus.i_primed = 1'b0;
    endtask

    task automatic pulse_probe(input logic [NCH-1:0] v);
        bus.i_probe = v;
        tick();
        bus.i_probe = '0;
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        bus.i_arm       = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_primed    = 1'b0;
        bus.i_force     = 1'b0;
        bus.i_probe     = '0;
        bus.i_mask      = '0;
        bus.i_polarity  = '0;
        bus.i_edge_mode = 1'b0;
        bus.i_combine   = COMB_OR;
        bus.i_holdoff   = '0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_state",   32'(bus.o_state), 32'd0);
        chk("rst_wr_en",   32'(bus.o_wr_en), 32'd0);
        chk("rst_trig_ch", 32'(bus.o_trig_ch), 32'd0);
        reset = 1'b0;

        // level OR, holdoff 5
        bus.i_mask = 4'b0001; bus.i_polarity = 4'b1111; bus.i_holdoff = 16'd5;
        post_cycles = 0;
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        chk("s1_fill", 32'(bus.o_state), 32'd1);
        tick();
        tick();
        bus.i_primed = 1'b1;
        tick();
        bus.i_primed = 1'b0;
        chk("s1_wait", 32'(bus.o_state), 32'd2);
        repeat (3) tick();
        bus.i_probe = 4'b0001;
        tick();
        bus.i_probe = '0;
        chk("s1_trig_early", 32'(bus.o_triggered), 32'd0);
        tick();
        chk("s1_trig", 32'(bus.o_triggered), 32'd1);
        chk("s1_post", 32'(bus.o_state), 32'd3);
        chk("s1_model_trig", 32'(mtrig), 32'd1);
        repeat (4) tick();
        chk("s1_still_wr", 32'(bus.o_wr_en), 32'd1);
        tick();
        chk("s1_stopped", 32'(bus.o_stopped), 32'd1);
        chk("s1_wr_off", 32'(bus.o_wr_en), 32'd0);
        chk("s1_trig_ch", 32'(bus.o_trig_ch), 32'h1);
        chk("s1_post_len", 32'(post_cycles), 32'd5);
        chk("s1_model_state", 32'(mst), 32'd4);

        // falling edge on channel 2
        bus.i_mask = 4'b0100; bus.i_polarity = 4'b0000; bus.i_edge_mode = 1'b1; bus.i_holdoff = 16'd2;
        arm_and_prime();
        repeat (6) tick();
        chk("s2_held_low", 32'(bus.o_triggered), 32'd0);
        chk("s2_wait", 32'(bus.o_state), 32'd2);
        bus.i_probe = 4'b0100;
        tick();
        bus.i_probe = 4'b0000;
        tick();
        chk("s2_edge_early", 32'(bus.o_triggered), 32'd0);
        tick();
        chk("s2_edge_trig", 32'(bus.o_triggered), 32'd1);
        chk("s2_trig_ch", 32'(bus.o_trig_ch), 32'h4);
        repeat (2) tick();
        chk("s2_stopped", 32'(bus.o_state), 32'd4);

        // AND combine, then forced trigger with empty mask
        bus.i_edge_mode = 1'b0; bus.i_combine = COMB_AND; bus.i_mask = 4'b0110;
        bus.i_polarity = 4'b1111; bus.i_holdoff = 16'd1;
        arm_and_prime();
        bus.i_probe = 4'b0100;
        repeat (4) tick();
        chk("s3_partial", 32'(bus.o_triggered), 32'd0);
        bus.i_probe = 4'b0110;
        tick();
        tick();
        bus.i_probe = '0;
        chk("s3_and_trig", 32'(bus.o_triggered), 32'd1);
        chk("s3_and_ch", 32'(bus.o_trig_ch), 32'h6);
        tick();
        chk("s3_stop", 32'(bus.o_state), 32'd4);
        bus.i_mask = 4'b0000; bus.i_probe = 4'b1111;
        arm_and_prime();
        repeat (3) tick();
        chk("s3_nomask", 32'(bus.o_triggered), 32'd0);
        bus.i_force = 1'b1;
        tick();
        bus.i_force = 1'b0;
        chk("s3_force", 32'(bus.o_triggered), 32'd1);
        chk("s3_force_ch", 32'(bus.o_trig_ch), 32'h0);
        tick();
        bus.i_probe = '0;

        // zero holdoff, hits ignored while filling
        bus.i_combine = COMB_OR; bus.i_mask = 4'b0001; bus.i_holdoff = 16'd0;
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        bus.i_probe = 4'b0001;
        repeat (4) tick();
        chk("s4_fill_ignores", 32'(bus.o_triggered), 32'd0);
        chk("s4_fill", 32'(bus.o_state), 32'd1);
        bus.i_probe = '0;
        repeat (2) tick();
        bus.i_primed = 1'b1;
        tick();
        bus.i_primed = 1'b0;
        bus.i_probe = 4'b0001;
        tick();
        bus.i_probe = '0;
        chk("s4_wait", 32'(bus.o_state), 32'd2);
        tick();
        chk("s4_direct_stop", 32'(bus.o_state), 32'd4);
        chk("s4_trig", 32'(bus.o_triggered), 32'd1);

        // abort beats simultaneous arm during POST
        bus.i_holdoff = 16'd8;
        arm_and_prime();
        pulse_probe(4'b0001);
        tick();
        chk("s5_in_post", 32'(bus.o_state), 32'd3);
        bus.i_arm = 1'b1; bus.i_abort = 1'b1;
        tick();
        bus.i_arm = 1'b0; bus.i_abort = 1'b0;
        chk("s5_idle", 32'(bus.o_state), 32'd0);
        chk("s5_trig_clr", 32'(bus.o_triggered), 32'd0);
        chk("s5_ch_clr", 32'(bus.o_trig_ch), 32'd0);
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
        chk("s5_rearm", 32'(bus.o_state), 32'd1);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;

        // reset during POST, then full capture with holdoff 3
        arm_and_prime();
        pulse_probe(4'b0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s6_rst_state", 32'(bus.o_state), 32'd0);
        chk("s6_rst_trig", 32'(bus.o_triggered), 32'd0);
        bus.i_holdoff = 16'd3;
        post_cycles = 0;
        arm_and_prime();
        pulse_probe(4'b0001);
        for (int n = 0; n < 20 && bus.o_state != 3'd4; n++) tick();
        chk("s6_stopped", 32'(bus.o_state), 32'd4);
        chk("s6_post_len", 32'(post_cycles), 32'd3);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.i_probe   = NCH'($urandom);
            bus.i_arm     = ($urandom % 12) == 0;
            bus.i_abort   = ($urandom % 90) == 0;
            bus.i_primed  = ($urandom % 4) == 0;
            bus.i_force   = ($urandom % 40) == 0;
            reset         = ($urandom % 700) == 0;
            if (($urandom % 50) == 0) begin
                bus.i_mask      = NCH'($urandom);
                bus.i_polarity  = NCH'($urandom);
                bus.i_edge_mode = 1'($urandom);
                bus.i_combine   = 1'($urandom);
            end
            if (($urandom % 7) == 0) bus.i_holdoff = HW'($urandom_range(0, 6));
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
